// File: rtl/wb_trace_pkg.sv
// rtl/wb_trace_pkg.sv - shared types and constants for the writeback trace capture block
//
// Purpose: default widths and the packed trace entry layout {seq, rd, data}.
package wb_trace_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int SEQ_W_DEF   = 16;
  localparam int NREGS       = 32;

  typedef struct packed {
    logic [SEQ_W_DEF-1:0]   seq;
    logic [RADDR_W_DEF-1:0] rd;
    logic [XLEN_DEF-1:0]    data;
  } trace_entry_t;

endpackage

// File: rtl/wb_trace_capture_fifo.sv
// rtl/wb_trace_capture_fifo.sv - synchronous FIFO of trace entries with valid/ready head
//
// Purpose: circular buffer with a separately tracked occupancy count so that
//          full and empty are distinguished while the pointers wrap naturally.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clear          synchronous flush (wins over push and pop)
//   push, push_data     offered entry
//   push_accepted  entry was stored this cycle
//   valid, ready, head  head entry handshake
//   count          current occupancy
module trace_fifo
  import wb_trace_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = trace_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  entry_t                 push_data,
  output logic                   push_accepted,
  output logic                   valid,
  input  logic                   ready,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic          full;
  logic          pop;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign valid = (cnt != '0);
  assign pop   = valid & ready & ~clear;
  // A pop in the same cycle frees the slot the push needs, so full+pop still accepts.
  assign push_accepted = push & ~clear & (~full | pop);
  // Masking keeps the head outputs at zero while empty, including straight after reset.
  assign head  = valid ? mem[rd_ptr] : '0;
  assign count = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (pop)           rd_ptr <= rd_ptr + AW'(1);
      if (push_accepted) wr_ptr <= wr_ptr + AW'(1);
      case ({push_accepted, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_accepted) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_trace_capture.sv
// rtl/wb_trace_capture.sv - writeback observer with shadow register file and trace FIFO
//
// Purpose: records every architectural register write (rd != 0) into a shadow
//          register file and a sequence-numbered trace FIFO.
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   wb_regwrite_i, wb_rd_i, wb_result_i  writeback port being observed
//   clear_i                           flush FIFO, sequence, overflow and drop count
//   trc_valid_o, trc_ready_i          head entry handshake
//   trc_seq_o, trc_rd_o, trc_data_o   head entry fields
//   shd_addr_i, shd_data_o            combinational shadow read port
//   count_o                           FIFO occupancy
//   overflow_o, drop_cnt_o            sticky drop flag, saturating drop count
module wb_trace_capture
  import wb_trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int SEQ_W   = SEQ_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_regwrite_i,
  input  logic [RADDR_W-1:0]     wb_rd_i,
  input  logic [XLEN-1:0]        wb_result_i,
  input  logic                   clear_i,
  output logic                   trc_valid_o,
  input  logic                   trc_ready_i,
  output logic [SEQ_W-1:0]       trc_seq_o,
  output logic [RADDR_W-1:0]     trc_rd_o,
  output logic [XLEN-1:0]        trc_data_o,
  input  logic [RADDR_W-1:0]     shd_addr_i,
  output logic [XLEN-1:0]        shd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  output logic [SEQ_W-1:0]       drop_cnt_o
);

  localparam int NSHD = 1 << RADDR_W;

  typedef struct packed {
    logic [SEQ_W-1:0]   seq;
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    data;
  } entry_t;

  logic [XLEN-1:0]  shadow [NSHD];
  logic [SEQ_W-1:0] seq_cnt;
  logic             wb_event;
  logic             accepted;
  entry_t           new_entry;
  entry_t           head;

  // x0 is hardwired zero in the CPU, so writes to it are not architectural events.
  assign wb_event  = wb_regwrite_i & (wb_rd_i != '0);
  assign new_entry = '{seq: seq_cnt, rd: wb_rd_i, data: wb_result_i};

  trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk           (clk),
    .rst           (reset),
    .clear         (clear_i),
    .push          (wb_event),
    .push_data     (new_entry),
    .push_accepted (accepted),
    .valid         (trc_valid_o),
    .ready         (trc_ready_i),
    .head          (head),
    .count         (count_o)
  );

  assign trc_seq_o  = head.seq;
  assign trc_rd_o   = head.rd;
  assign trc_data_o = head.data;

  assign shd_data_o = (shd_addr_i == '0) ? '0 : shadow[shd_addr_i];

  // Shadow state survives clear_i; only reset wipes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSHD; i++) shadow[i] <= '0;
    end else if (wb_event) begin
      shadow[wb_rd_i] <= wb_result_i;
    end
  end

  // Sequence advances on every event, accepted or dropped, so gaps reveal drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_cnt    <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (clear_i) begin
      seq_cnt    <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (wb_event) begin
      seq_cnt <= seq_cnt + SEQ_W'(1);
      if (!accepted) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + SEQ_W'(1);
      end
    end
  end

endmodule
